measure_result_fifo: RTL

Read-side consumer for the frequency-measurement result stream. Captures each 64-bit result written by the measurement core (`reg_wr_en`/`reg_wr_data`) into a small FIFO and serves it to the register-read path as 32-bit words, with status, overflow tracking and a level interrupt. Sits between the measurement core and the AXI register slave.

---
 rtl/measure_result_fifo.sv | 123 ++++++++++++
 1 files changed

// File: rtl/measure_result_fifo.sv
// Result FIFO between the measurement core and the register read path: 64-bit entries served as 32-bit words.
// Optional level interrupt compiled in with `define MEASURE_RESULT_FIFO_IRQ_EN; irq_o is tied low otherwise.
module measure_result_fifo #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned IRQ_LEVEL  = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        reg_wr_en_i,
    input  logic [63:0] reg_wr_data_i,
    input  logic        rd_en_i,
    input  logic [1:0]  rd_addr_i,
    output logic        rd_valid_o,
    output logic [31:0] rd_data_o,
    output logic        irq_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_DATA_LO = 2'd1;
    localparam logic [1:0] ADDR_DATA_HI = 2'd2;

    // Parameter legality is checked at elaboration.
    generate
        if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 8) begin : g_bad_depth
            $error("measure_result_fifo: DEPTH_LOG2 must be 1..8");
        end
        if (IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_irq_level
            $error("measure_result_fifo: IRQ_LEVEL must be 1..2^DEPTH_LOG2");
        end
    endgenerate

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             rd_valid_q, rd_valid_d;
    logic [31:0]      rd_data_q, rd_data_d;

    logic        empty, full, pop, push, ovf_set, status_rd;
    logic [63:0] head;

    assign empty     = (level_q == '0);
    assign full      = (level_q == LVL_W'(DEPTH));
    assign head      = mem_q[rd_ptr_q];
    assign status_rd = rd_en_i && (rd_addr_i == ADDR_STATUS);
    assign pop       = rd_en_i && (rd_addr_i == ADDR_DATA_HI) && !empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted.
    assign push      = reg_wr_en_i && (!full || pop);
    assign ovf_set   = reg_wr_en_i && !push;

    // Next-state for pointers, level, overflow flag and the registered read response.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        rd_valid_d = rd_en_i;
        rd_data_d  = rd_data_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        if (push && !pop)      level_d = level_q + LVL_W'(1);
        else if (pop && !push) level_d = level_q - LVL_W'(1);

        if (ovf_set)        ovf_d = 1'b1;
        else if (status_rd) ovf_d = 1'b0;

        if (rd_en_i) begin
            case (rd_addr_i)
                ADDR_STATUS:  rd_data_d = {ovf_q, full, empty, 13'd0, 16'(level_q)};
                ADDR_DATA_LO: rd_data_d = empty ? 32'h0 : head[31:0];
                ADDR_DATA_HI: rd_data_d = empty ? 32'h0 : head[63:32];
                default:      rd_data_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'h0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= reg_wr_data_i;
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

`ifdef MEASURE_RESULT_FIFO_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) irq_q <= 1'b0;
        else       irq_q <= (level_d >= LVL_W'(IRQ_LEVEL)) || ovf_d;
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule
